// File: rtl/data_bus_mem_if.sv
// CPU data-bus bundle between a master (core or bench) and data_bus_mem.
// Carries CS, WR_RD, ADDR, DATA_IN toward memory; DATA_OUT, READY, ERR back.
interface data_bus_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              CS;
    logic              WR_RD;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] DATA_IN;
    logic [DATA_W-1:0] DATA_OUT;
    logic              READY;
    logic              ERR;

    modport master (
        output CS, WR_RD, ADDR, DATA_IN,
        input  DATA_OUT, READY, ERR
    );

    modport slave (
        input  CS, WR_RD, ADDR, DATA_IN,
        output DATA_OUT, READY, ERR
    );
endinterface

// File: rtl/data_bus_mem.sv
// Wait-state data memory for the CPU data bus with a one-cycle READY pulse.
// Ports: CLK, RST (sync, active-high), bus (data_bus_mem_if.slave).
// Optional MEM_BOUNDS_CHECK_EN: out-of-range accesses raise ERR instead of wrapping.
module data_bus_mem #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int ADDR_LSB    = 2,
    parameter int WAIT_STATES = 1
) (
    input  logic          CLK,
    input  logic          RST,
    data_bus_mem_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic              wr_q;
    logic              oob_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] rd_word;
    logic              in_oob;
    logic              accept;
    logic              unused_addr;

    logic [DATA_W-1:0] mem [DEPTH];

    // Low byte-lane bits (and, without the check, the high bits) are dropped.
    assign unused_addr = ^bus.ADDR;

`ifdef MEM_BOUNDS_CHECK_EN
    logic [ADDR_W-1:0] full_idx;
    assign full_idx = bus.ADDR >> ADDR_LSB;
    assign in_oob   = full_idx >= ADDR_W'(DEPTH);
`else
    assign in_oob = 1'b0;
`endif

    assign accept = (state_q == IDLE) && bus.CS;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.CS) state_d = (WAIT_STATES == 0) ? DONE : WAIT;
            WAIT: if (cnt_q == 4'd1) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= WS;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (state_q == DONE && !wr_q) begin
                hold_q <= rd_word;
            end
        end
    end

    // Request fields are only meaningful while busy, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            idx_q   <= bus.ADDR[ADDR_LSB +: IDX_W];
            wr_q    <= bus.WR_RD;
            wdata_q <= bus.DATA_IN;
            oob_q   <= in_oob;
        end
    end

    // A reset on the DONE edge abandons the write as well.
    always_ff @(posedge CLK) begin
        if (!RST && state_q == DONE && wr_q && !oob_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign rd_word = oob_q ? '0 : mem[idx_q];

    // The read word is visible during DONE itself, then held in hold_q.
    assign bus.DATA_OUT = (state_q == DONE && !wr_q) ? rd_word : hold_q;
    assign bus.READY    = (state_q == DONE);
    assign bus.ERR      = (state_q == DONE) && oob_q;
endmodule

// File: tb/tb_data_bus_mem.sv
// Directed bench for data_bus_mem: three instances (0, 2, 3 wait states)
// share one stimulus bus; sel picks the instance being observed.
module tb_data_bus_mem;
    logic        clk;
    logic        rst;
    logic        cs;
    logic        wr_rd;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  sel;
    logic        rdy;
    logic        err;
    logic [31:0] dout;

    int n_chk;
    int n_pass;
    int lat;
    int seen;

    data_bus_mem_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
    data_bus_mem_if #(.DATA_W(32), .ADDR_W(32)) bus2 ();
    data_bus_mem_if #(.DATA_W(32), .ADDR_W(32)) bus3 ();

    assign bus0.CS = cs;
    assign bus0.WR_RD = wr_rd;
    assign bus0.ADDR = addr;
    assign bus0.DATA_IN = din;
    assign bus2.CS = cs;
    assign bus2.WR_RD = wr_rd;
    assign bus2.ADDR = addr;
    assign bus2.DATA_IN = din;
    assign bus3.CS = cs;
    assign bus3.WR_RD = wr_rd;
    assign bus3.ADDR = addr;
    assign bus3.DATA_IN = din;

    data_bus_mem #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
        .CLK(clk), .RST(rst), .bus(bus0)
    );
    data_bus_mem #(.DEPTH(256), .WAIT_STATES(2)) dut2 (
        .CLK(clk), .RST(rst), .bus(bus2)
    );
    data_bus_mem #(.DEPTH(256), .WAIT_STATES(3)) dut3 (
        .CLK(clk), .RST(rst), .bus(bus3)
    );

    assign rdy  = (sel == 2'd0) ? bus0.READY :
                  (sel == 2'd2) ? bus2.READY : bus3.READY;
    assign err  = (sel == 2'd0) ? bus0.ERR :
                  (sel == 2'd2) ? bus2.ERR : bus3.ERR;
    assign dout = (sel == 2'd0) ? bus0.DATA_OUT :
                  (sel == 2'd2) ? bus2.DATA_OUT : bus3.DATA_OUT;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // One single-cycle request; returns cycles from acceptance to READY.
    task automatic xact(input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int l);
        cs = 1'b1;
        wr_rd = wr;
        addr = a;
        din = d;
        step();
        cs = 1'b0;
        l = 1;
        while (!rdy && l < 32) begin
            step();
            l++;
        end
    endtask

    logic [31:0] exp0;
    logic        exp_err;
    logic [31:0] exp_oob_rd;

    initial begin
        n_chk = 0;
        n_pass = 0;
        sel = 2'd2;
        rst = 1'b1;
        cs = 1'b0;
        wr_rd = 1'b0;
        addr = '0;
        din = '0;
`ifdef MEM_BOUNDS_CHECK_EN
        exp0 = 32'h77;
        exp_err = 1'b1;
        exp_oob_rd = 32'h0;
`else
        exp0 = 32'h55;
        exp_err = 1'b0;
        exp_oob_rd = 32'h55;
`endif

        idle(2);
        chk("rst ready", {31'd0, rdy}, 32'd0);
        chk("rst dout", dout, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        idle(1);

        // 2 wait states: write then read back
        xact(1'b1, 32'h10, 32'hDEADBEEF, lat);
        chk("wr lat", lat, 32'd3);
        chk("wr dout kept", dout, 32'd0);
        step();
        chk("wr ready pulse", {31'd0, rdy}, 32'd0);
        xact(1'b0, 32'h10, 32'h0, lat);
        chk("rd lat", lat, 32'd3);
        chk("rd data", dout, 32'hDEADBEEF);
        step();
        chk("rd ready pulse", {31'd0, rdy}, 32'd0);
        chk("rd data held", dout, 32'hDEADBEEF);
        xact(1'b1, 32'h14, 32'h11112222, lat);
        chk("wr no dout", dout, 32'hDEADBEEF);
        step();
        xact(1'b0, 32'h13, 32'h0, lat);
        chk("lsb ignored", dout, 32'hDEADBEEF);
        step();

        // wrap / bounds
        xact(1'b1, 32'h0, 32'h77, lat);
        step();
        xact(1'b1, 32'h400, 32'h55, lat);
        chk("oob wr err", {31'd0, err}, {31'd0, exp_err});
        chk("oob wr ready", {31'd0, rdy}, 32'd1);
        step();
        chk("err clear", {31'd0, err}, 32'd0);
        xact(1'b0, 32'h0, 32'h0, lat);
        chk("wrap rd 0", dout, exp0);
        chk("in-range err", {31'd0, err}, 32'd0);
        step();
        xact(1'b0, 32'h400, 32'h0, lat);
        chk("oob rd data", dout, exp_oob_rd);
        chk("oob rd err", {31'd0, err}, {31'd0, exp_err});
        idle(6);

        // 0 wait states: back-to-back reads with CS held
        sel = 2'd0;
        xact(1'b1, 32'h4, 32'hCAFEF00D, lat);
        chk("ws0 lat", lat, 32'd1);
        step();
        cs = 1'b1;
        wr_rd = 1'b0;
        addr = 32'h0;
        step();
        chk("b2b rdy1", {31'd0, rdy}, 32'd1);
        chk("b2b data1", dout, exp0);
        addr = 32'h4;
        step();
        chk("b2b gap", {31'd0, rdy}, 32'd0);
        chk("b2b gap data", dout, exp0);
        step();
        chk("b2b rdy2", {31'd0, rdy}, 32'd1);
        chk("b2b data2", dout, 32'hCAFEF00D);
        cs = 1'b0;
        step();
        chk("b2b end", {31'd0, rdy}, 32'd0);
        idle(6);

        // 3 wait states: reset abandons a write
        sel = 2'd3;
        xact(1'b1, 32'h20, 32'h5A5A, lat);
        chk("ws3 lat", lat, 32'd4);
        step();
        cs = 1'b1;
        wr_rd = 1'b1;
        addr = 32'h20;
        din = 32'h1234;
        step();
        cs = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort dout", dout, 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rdy) seen++;
            step();
        end
        chk("abort no ready", seen, 32'd0);
        xact(1'b0, 32'h20, 32'h0, lat);
        chk("abort old data", dout, 32'h5A5A);
        idle(6);

        // 2 wait states: inputs changed during WAIT are ignored
        sel = 2'd2;
        xact(1'b1, 32'h34, 32'h34343434, lat);
        step();
        cs = 1'b1;
        wr_rd = 1'b1;
        addr = 32'h30;
        din = 32'h600DD00D;
        step();
        cs = 1'b0;
        addr = 32'h34;
        din = 32'h00000BAD;
        lat = 1;
        while (!rdy && lat < 32) begin
            step();
            lat++;
        end
        chk("latch lat", lat, 32'd3);
        step();
        xact(1'b0, 32'h30, 32'h0, lat);
        chk("latched addr", dout, 32'h600DD00D);
        step();
        xact(1'b0, 32'h34, 32'h0, lat);
        chk("other untouched", dout, 32'h34343434);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
